// File: rtl/pipeline_controller_if.sv
// Control bundle between the pipeline sequencer and the fetch/decode blocks.
// The slave side is the controller; the master side drives decode/EX status.
interface pipeline_controller_if #(
   parameter int OP_W = 16
);
   logic            start;
   logic [4:0]      id_rs;
   logic [4:0]      id_rt;
   logic            id_uses_rs;
   logic            id_uses_rt;
   logic            ex_valid;
   logic [OP_W-1:0] ex_op;
   logic [4:0]      ex_rd;
   logic            branch_taken;
   logic            pc_en;
   logic            if_id_en;
   logic            if_id_flush;
   logic            id_ex_en;
   logic            id_ex_bubble;
   logic            mul_busy;
   logic            halted;
   logic [1:0]      state;

   modport master (
      output start, id_rs, id_rt, id_uses_rs, id_uses_rt,
             ex_valid, ex_op, ex_rd, branch_taken,
      input  pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_bubble,
             mul_busy, halted, state
   );

   modport slave (
      input  start, id_rs, id_rt, id_uses_rs, id_uses_rt,
             ex_valid, ex_op, ex_rd, branch_taken,
      output pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_bubble,
             mul_busy, halted, state
   );
endinterface

// File: rtl/pipeline_controller.sv
// Fetch-decode-execute sequencer: stage enables, RAW stalls, branch flushes,
// multi-cycle MUL freeze and terminal HALT. Control only, no datapath.
module pipeline_controller #(
   parameter int MUL_CYCLES = 4,
   parameter int OP_W       = 16
) (
   input  logic                  clock,
   input  logic                  reset_n,
   pipeline_controller_if.slave  bus
);
   localparam int CNT_W   = $clog2(MUL_CYCLES) + 1;
   localparam int NUM_OPS = 15;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      RUN      = 2'd1,
      MUL_WAIT = 2'd2,
      HALT     = 2'd3
   } state_t;

   state_t           state_reg, state_next;
   logic [CNT_W-1:0] cnt_reg, cnt_next;
   logic             mul_done_reg, mul_done_next;

   // Exact one-hot match per opcode; zero or multi-hot values hit nothing.
   logic [NUM_OPS-1:0] op_hit;
   genvar gi;
   generate
      for (gi = 0; gi < NUM_OPS; gi++) begin : g_op
         assign op_hit[gi] = (bus.ex_op == (OP_W'(1) << gi));
      end
   endgenerate

   logic writes_rd, is_branch, is_mul, is_hlt, raw_hit;
   assign writes_rd = (|op_hit[7:0]) | op_hit[10] | op_hit[11] | op_hit[12];
   assign is_branch = op_hit[8] | op_hit[9];
   assign is_mul    = op_hit[12];
   assign is_hlt    = op_hit[13];
   assign raw_hit   = bus.ex_valid && writes_rd &&
                      ((bus.id_uses_rs && (bus.id_rs == bus.ex_rd)) ||
                       (bus.id_uses_rt && (bus.id_rt == bus.ex_rd)));

   logic pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_bubble, mul_busy, halted;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_reg    <= IDLE;
         cnt_reg      <= '0;
         mul_done_reg <= 1'b0;
      end else begin
         state_reg    <= state_next;
         cnt_reg      <= cnt_next;
         mul_done_reg <= mul_done_next;
      end
   end

   always_comb begin
      state_next    = state_reg;
      cnt_next      = cnt_reg;
      mul_done_next = mul_done_reg;
      pc_en         = 1'b0;
      if_id_en      = 1'b0;
      if_id_flush   = 1'b0;
      id_ex_en      = 1'b0;
      id_ex_bubble  = 1'b0;
      mul_busy      = 1'b0;
      halted        = 1'b0;
      case (state_reg)
         IDLE: begin
            if (bus.start) state_next = RUN;
         end
         RUN: begin
            pc_en         = 1'b1;
            if_id_en      = 1'b1;
            id_ex_en      = 1'b1;
            mul_done_next = 1'b0;
            if (bus.ex_valid && is_hlt) begin
               pc_en        = 1'b0;
               if_id_en     = 1'b0;
               id_ex_bubble = 1'b1;
               state_next   = HALT;
            end else if (bus.ex_valid && is_branch && bus.branch_taken) begin
               // Branch wins over a RAW match: the dependent word is flushed anyway.
               if_id_flush  = 1'b1;
               id_ex_bubble = 1'b1;
            end else if (bus.ex_valid && is_mul && !mul_done_reg && (MUL_CYCLES > 1)) begin
               pc_en      = 1'b0;
               if_id_en   = 1'b0;
               id_ex_en   = 1'b0;
               cnt_next   = CNT_W'(MUL_CYCLES - 1);
               state_next = MUL_WAIT;
            end else if (raw_hit) begin
               pc_en        = 1'b0;
               if_id_en     = 1'b0;
               id_ex_bubble = 1'b1;
            end
         end
         MUL_WAIT: begin
            mul_busy = 1'b1;
            cnt_next = cnt_reg - CNT_W'(1);
            if (cnt_reg == CNT_W'(1)) begin
               state_next    = RUN;
               mul_done_next = 1'b1;
            end
         end
         HALT: begin
            halted = 1'b1;
         end
         default: state_next = IDLE;
      endcase
   end

   assign bus.pc_en        = pc_en;
   assign bus.if_id_en     = if_id_en;
   assign bus.if_id_flush  = if_id_flush;
   assign bus.id_ex_en     = id_ex_en;
   assign bus.id_ex_bubble = id_ex_bubble;
   assign bus.mul_busy     = mul_busy;
   assign bus.halted       = halted;
   assign bus.state        = state_reg;
endmodule

// File: tb/tb_pipeline_controller.sv
// Self-checking bench for pipeline_controller: directed scenarios plus random
// traffic compared against a cycle-level behavioural model.
module tb_pipeline_controller;
   localparam int MC   = 4;
   localparam int OP_W = 16;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   pipeline_controller_if #(.OP_W(OP_W)) bus ();
   pipeline_controller #(.MUL_CYCLES(MC), .OP_W(OP_W)) dut (
      .clock   (clk),
      .reset_n (rst_n),
      .bus     (bus.slave)
   );

   int checks = 0;
   int errors = 0;

   // Model: mode 0 idle, 1 run, 2 mul freeze, 3 halted; left = freeze cycles still to go.
   int m_mode, m_left, n_mode, n_left;
   bit m_skip, n_skip;
   logic [8:0] exp_vec;

   function automatic logic [8:0] out_vec();
      return {bus.pc_en, bus.if_id_en, bus.if_id_flush, bus.id_ex_en,
              bus.id_ex_bubble, bus.mul_busy, bus.halted, bus.state};
   endfunction

   function automatic logic [8:0] model_eval(output int nmode, output int nleft, output bit nskip);
      int  opn;
      bit  wr, dep;
      bit  pc, ifid, fl, idex, bub, busy, hlt;
      opn = -1;
      if ($countones(bus.ex_op) == 1)
         for (int i = 0; i < OP_W; i++) if (bus.ex_op[i]) opn = i;
      wr  = (opn >= 0 && opn <= 7) || opn == 10 || opn == 11 || opn == 12;
      dep = (bus.id_uses_rs && bus.id_rs == bus.ex_rd) || (bus.id_uses_rt && bus.id_rt == bus.ex_rd);
      {pc, ifid, fl, idex, bub, busy, hlt} = '0;
      nmode = m_mode; nleft = m_left; nskip = m_skip;
      if (m_mode == 0) begin
         if (bus.start) nmode = 1;
      end else if (m_mode == 1) begin
         {pc, ifid, idex} = 3'b111;
         nskip = 0;
         if (bus.ex_valid && opn == 13) begin
            pc = 0; ifid = 0; bub = 1; nmode = 3;
         end else if (bus.ex_valid && (opn == 8 || opn == 9) && bus.branch_taken) begin
            fl = 1; bub = 1;
         end else if (bus.ex_valid && opn == 12 && !m_skip && MC > 1) begin
            {pc, ifid, idex} = 3'b000; nmode = 2; nleft = MC - 1;
         end else if (bus.ex_valid && wr && dep) begin
            pc = 0; ifid = 0; bub = 1;
         end
      end else if (m_mode == 2) begin
         busy  = 1;
         nleft = m_left - 1;
         if (nleft == 0) begin nmode = 1; nskip = 1; end
      end else begin
         hlt = 1;
      end
      return {pc, ifid, fl, idex, bub, busy, hlt, 2'(m_mode)};
   endfunction

   task automatic model_reset();
      m_mode = 0; m_left = 0; m_skip = 0;
   endtask

   task automatic settle();
      @(negedge clk);
      exp_vec = model_eval(n_mode, n_left, n_skip);
   endtask

   task automatic commit();
      @(posedge clk);
      m_mode = n_mode; m_left = n_left; m_skip = n_skip;
      #1;
   endtask

   task automatic nop_inputs();
      bus.start = 0; bus.ex_valid = 1; bus.ex_op = 16'h4000; bus.ex_rd = 5'd0;
      bus.id_rs = 5'd1; bus.id_rt = 5'd2; bus.id_uses_rs = 0; bus.id_uses_rt = 0;
      bus.branch_taken = 0;
   endtask

   task automatic restart();
      @(negedge clk);
      rst_n = 0;
      #2 rst_n = 1;
      model_reset();
      @(posedge clk);
      #1 bus.start = 1;
      settle();
      commit();
      bus.start = 0;
   endtask

   task automatic test_reset();
      nop_inputs();
      model_reset();
      rst_n = 0;
      #12;
      checks++;
      if (out_vec() !== 9'd0) begin
         errors++; $display("FAIL reset_outputs got=%b exp=%b", out_vec(), 9'd0);
      end
      @(negedge clk) rst_n = 1;
   endtask

   task automatic test_start();
      @(posedge clk); #1;
      bus.start = 1;
      settle();
      checks++;
      if (out_vec() !== exp_vec) begin errors++; $display("FAIL start_idle got=%b exp=%b", out_vec(), exp_vec); end
      commit();
      bus.start = 0;
      settle();
      checks++;
      if (bus.state !== 2'd1 || {bus.pc_en, bus.if_id_en, bus.id_ex_en} !== 3'b111) begin
         errors++; $display("FAIL start_run got=%b exp_state=1 enables=111", out_vec());
      end
      commit();
   endtask

   task automatic test_raw();
      bus.ex_op = 16'h0001; bus.ex_rd = 5'd5; bus.id_rs = 5'd5; bus.id_uses_rs = 1;
      settle();
      checks++;
      if (out_vec() !== exp_vec || {bus.pc_en, bus.if_id_en, bus.id_ex_bubble} !== 3'b001) begin
         errors++; $display("FAIL raw_stall got=%b exp=%b", out_vec(), exp_vec);
      end
      commit();
      bus.ex_op = 16'h4000;
      settle();
      checks++;
      if (out_vec() !== exp_vec || out_vec() !== 9'b110100001) begin
         errors++; $display("FAIL raw_release got=%b exp=%b", out_vec(), 9'b110100001);
      end
      commit();
      bus.ex_op = 16'h0001; bus.ex_rd = 5'd6;
      settle();
      checks++;
      if (out_vec() !== exp_vec || out_vec() !== 9'b110100001) begin
         errors++; $display("FAIL raw_nomatch got=%b exp=%b", out_vec(), 9'b110100001);
      end
      commit();
      bus.ex_op = 16'h0800; bus.ex_rd = 5'd7; bus.id_uses_rs = 0; bus.id_uses_rt = 1; bus.id_rt = 5'd7;
      settle();
      checks++;
      if (out_vec() !== exp_vec || out_vec() !== 9'b000110001) begin
         errors++; $display("FAIL raw_rt got=%b exp=%b", out_vec(), 9'b000110001);
      end
      commit();
      nop_inputs();
   endtask

   task automatic test_branch();
      bus.ex_op = 16'h0200; bus.branch_taken = 1;
      settle();
      checks++;
      if (out_vec() !== exp_vec || out_vec() !== 9'b111110001) begin
         errors++; $display("FAIL branch_taken got=%b exp=%b", out_vec(), 9'b111110001);
      end
      commit();
      bus.branch_taken = 0;
      settle();
      checks++;
      if (out_vec() !== exp_vec || out_vec() !== 9'b110100001) begin
         errors++; $display("FAIL branch_not_taken got=%b exp=%b", out_vec(), 9'b110100001);
      end
      commit();
      nop_inputs();
   endtask

   task automatic test_mul();
      int frozen, busy;
      frozen = 0; busy = 0;
      bus.ex_op = 16'h1000; bus.ex_rd = 5'd9;
      for (int c = 0; c < MC + 1; c++) begin
         settle();
         checks++;
         if (out_vec() !== exp_vec) begin errors++; $display("FAIL mul_cycle%0d got=%b exp=%b", c, out_vec(), exp_vec); end
         if ({bus.pc_en, bus.if_id_en, bus.id_ex_en} == 3'b000) frozen++;
         if (bus.mul_busy) busy++;
         commit();
      end
      checks++;
      if (frozen !== MC || busy !== MC - 1) begin
         errors++; $display("FAIL mul_length got frozen=%0d busy=%0d exp frozen=%0d busy=%0d", frozen, busy, MC, MC - 1);
      end
      nop_inputs();
   endtask

   task automatic test_mul_reset();
      bus.ex_op = 16'h1000;
      settle(); commit();
      settle(); commit();
      #2 rst_n = 0;
      #1;
      checks++;
      if (out_vec() !== 9'd0 || dut.cnt_reg !== '0) begin
         errors++; $display("FAIL mul_reset got=%b cnt=%0d exp=%b cnt=0", out_vec(), dut.cnt_reg, 9'd0);
      end
      model_reset();
      nop_inputs();
      @(negedge clk) rst_n = 1;
      restart();
   endtask

   task automatic test_hlt();
      bus.ex_op = 16'h2000;
      settle();
      checks++;
      if (out_vec() !== exp_vec || out_vec() !== 9'b000110001) begin
         errors++; $display("FAIL hlt_bubble got=%b exp=%b", out_vec(), 9'b000110001);
      end
      commit();
      nop_inputs();
      for (int c = 0; c < 3; c++) begin
         bus.start = 1'(c & 1);
         settle();
         checks++;
         if (out_vec() !== exp_vec || out_vec() !== 9'b000000111) begin
            errors++; $display("FAIL hlt_stay%0d got=%b exp=%b", c, out_vec(), 9'b000000111);
         end
         commit();
      end
      nop_inputs();
      restart();
   endtask

   task automatic test_priority();
      bus.ex_op = 16'h0100; bus.branch_taken = 1; bus.ex_rd = 5'd3;
      bus.id_rs = 5'd3; bus.id_uses_rs = 1;
      settle();
      checks++;
      if (out_vec() !== exp_vec || out_vec() !== 9'b111110001) begin
         errors++; $display("FAIL prio_branch got=%b exp=%b", out_vec(), 9'b111110001);
      end
      commit();
      bus.ex_op = 16'h0003; bus.branch_taken = 0;
      settle();
      checks++;
      if (out_vec() !== exp_vec || out_vec() !== 9'b110100001) begin
         errors++; $display("FAIL multihot got=%b exp=%b", out_vec(), 9'b110100001);
      end
      commit();
      bus.ex_op = 16'h0000;
      settle();
      checks++;
      if (out_vec() !== exp_vec || out_vec() !== 9'b110100001) begin
         errors++; $display("FAIL zero_op got=%b exp=%b", out_vec(), 9'b110100001);
      end
      commit();
      nop_inputs();
   endtask

   task automatic test_random();
      int r;
      for (int c = 0; c < 600; c++) begin
         if (m_mode == 3 && $urandom_range(0, 3) == 0) restart();
         r = $urandom_range(0, 19);
         if (r == 13 && $urandom_range(0, 7) != 0) r = 14;
         if (r < 15) bus.ex_op = 16'(1 << r);
         else if (r == 15) bus.ex_op = 16'h0000;
         else bus.ex_op = 16'($urandom);
         bus.ex_valid     = ($urandom_range(0, 4) != 0);
         bus.ex_rd        = 5'($urandom_range(0, 3));
         bus.id_rs        = 5'($urandom_range(0, 3));
         bus.id_rt        = 5'($urandom_range(0, 3));
         bus.id_uses_rs   = 1'($urandom);
         bus.id_uses_rt   = 1'($urandom);
         bus.branch_taken = 1'($urandom);
         bus.start        = ($urandom_range(0, 7) == 0);
         settle();
         checks++;
         if (out_vec() !== exp_vec) begin
            errors++; $display("FAIL random%0d op=%h got=%b exp=%b", c, bus.ex_op, out_vec(), exp_vec);
         end
         commit();
      end
      nop_inputs();
   endtask

   initial begin
      test_reset();
      test_start();
      test_raw();
      test_branch();
      test_mul();
      test_mul_reset();
      test_priority();
      test_hlt();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/pipeline_controller.md
Name: pipeline_controller

Overview:
Central sequencing controller for the fetch-decode-execute pipeline. It drives the stage-register enables (PC, IF_ID, ID_EX) from the decoded one-hot opcode in EX, the decode-stage source registers and the branch outcome. It generates RAW-hazard stalls, branch flushes, multi-cycle MUL freezes and the terminal HLT state. It contains no datapath; all outputs are control strobes consumed by the fetch and decode blocks.

Parameters:
MUL_CYCLES, 4, total cycles the pipeline is frozen per MUL (>=1; 1 = no freeze)
OP_W, 16, width of one-hot opcode field (ID_EX[175:160])

Ports:
clock  in  1  pipeline clock, rising edge
reset_n  in  1  asynchronous active-low reset
start  in  1  begin execution from IDLE
id_rs  in  5  source register of instruction in decode (IF_ID[25:21])
id_rt  in  5  target register of instruction in decode (IF_ID[20:16])
id_uses_rs  in  1  decode instruction reads id_rs
id_uses_rt  in  1  decode instruction reads id_rt
ex_valid  in  1  ID_EX holds a real instruction
ex_op  in  OP_W  one-hot opcode in EX (ID_EX[175:160])
ex_rd  in  5  destination register in EX (ID_EX[100:96])
branch_taken  in  1  EX branch condition true (valid only for BR/BNE)
pc_en  out  1  PC advances or loads branch target
if_id_en  out  1  IF_ID register loads
if_id_flush  out  1  IF_ID loaded with NOP instead of fetched word
id_ex_en  out  1  ID_EX register loads
id_ex_bubble  out  1  ID_EX op field loaded with NOP (bit 14) instead of decoded op
mul_busy  out  1  MUL freeze in progress
halted  out  1  HLT retired; pipeline stopped
state  out  2  IDLE=0, RUN=1, MUL_WAIT=2, HALT=3

Behaviour:
- Architecture: state register, wait counter (clog2(MUL_CYCLES)+1 bits) and mul_done flag are registered. Control outputs are combinational from state, registers and current inputs.
- Reset (async, reset_n=0): state=IDLE, counter=0, mul_done=0. Every output is 0 except state=0. Reset asserted in any state, including MUL_WAIT, returns to IDLE immediately.
- Opcode match uses exact one-hot equality: ADD=bit0 … XOR=bit7, BR=bit8, BNE=bit9, MOV=bit10, ADI=bit11, MUL=bit12, HLT=bit13, NOP=bit14.
  - writes_rd = ex_op equals any of bits 0-7, 10, 11 or 12.
  - Zero-valued or multi-hot ex_op is treated as NOP: no action, no hazard.
- IDLE: all enables 0. start=1 moves to RUN next cycle.
- RUN: default pc_en = if_id_en = id_ex_en = 1, flush = bubble = 0. Only the first matching condition below acts:
  1. ex_valid and HLT: pc_en=0, if_id_en=0, id_ex_bubble=1. Next state HALT.
  2. ex_valid and (BR or BNE) and branch_taken: if_id_flush=1, id_ex_bubble=1, pc_en=1 (target load). Stay in RUN.
  3. ex_valid and MUL and mul_done=0 and MUL_CYCLES>1: pc_en = if_id_en = id_ex_en = 0, counter <= MUL_CYCLES-1, next state MUL_WAIT.
  4. RAW hazard: ex_valid and writes_rd and ((id_uses_rs and id_rs==ex_rd) or (id_uses_rt and id_rt==ex_rd)). Result: pc_en=0, if_id_en=0, id_ex_bubble=1 (one-cycle stall). r0 is not special.
  - Not-taken BR/BNE: no action.
- MUL_WAIT: all enables 0, mul_busy=1.
  - counter==1: next state RUN and mul_done <= 1. Otherwise counter decrements.
  - Freeze therefore lasts exactly MUL_CYCLES cycles, counting the detect cycle.
- mul_done suppresses rule 3 for the first RUN cycle after MUL_WAIT. That cycle advances normally, with rule 4 still evaluated. mul_done clears at the end of any RUN cycle.
- HALT: all enables 0, halted=1. start is ignored. Only reset exits.
- start is ignored outside IDLE.
- A simultaneous RAW match and taken branch resolves to the branch (rule 2): the flushed instruction needs no stall.

Test Plan:
- Reset/start: reset_n=0 mid-run → state=0 and all enables 0 in the same cycle. Release, then start=1 for 1 cycle → state=1 and pc_en=if_id_en=id_ex_en=1 next cycle.
- RAW stall: ex_op=0x0001 (ADD), ex_rd=5, id_rs=5, id_uses_rs=1 → one cycle with pc_en=0, if_id_en=0, id_ex_bubble=1. Next cycle (ex_op=0x4000) → all enables 1. Same stimulus with ex_rd=6 → no stall.
- Taken branch: ex_op=0x0200 (BNE), branch_taken=1 → if_id_flush=1, id_ex_bubble=1, pc_en=1 for one cycle. With branch_taken=0 → no flush.
- MUL freeze, MUL_CYCLES=4: ex_op=0x1000 held → enables 0 for exactly 4 cycles and mul_busy=1 for 3 of them, then one normal advance cycle with no re-trigger. Reset during the 2nd MUL_WAIT cycle → IDLE, counter 0.
- HLT: ex_op=0x2000 → bubble for 1 cycle, then state=3, halted=1, all enables 0. start=1 pulses leave state=3 unchanged.
- Priority and illegal opcodes: ex_op=0x0100 (BR) taken, with id_rs==ex_rd → flush only, no stall. ex_op=0x0003 (multi-hot) → treated as NOP, enables 1.
